mult_div_unit: RTL



---
 rtl/mdu_pkg.sv | 25 ++
 rtl/negate_32bit.sv | 21 ++
 rtl/mult_div_unit.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   mdu_op_e : operation encodings driven on mult_div_unit.op
//   state_t  : controller states
//   MDU_WIDTH: default operand width
//   DIV0_LO  : LO value written on divide by zero
package mdu_pkg;

    localparam int MDU_WIDTH = 32;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } state_t;

    localparam logic [MDU_WIDTH-1:0] DIV0_LO = '1;

endpackage

// File: rtl/negate_32bit.sv
// Conditional two's-complement negate.
//   din  : value to negate
//   en   : 1 -> dout = -din, 0 -> dout = din
//   dout : result
// Width defaults to 32; the 64-bit product sign fix uses W = 64.
module negate_32bit #(
    parameter int W = 32
) (
    input  logic [W-1:0] din,
    input  logic         en,
    output logic [W-1:0] dout
);

    always_comb begin
        dout = din;
        if (en) begin
            dout = (~din) + W'(1);
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit producing the HI/LO pair.
//   clk, reset         : clock, synchronous active-high reset
//   start, op          : launch an operation (accepted only in IDLE)
//   src1, src2         : rs / rt operands
//   hi_we, lo_we, wdata: MTHI / MTLO writes (IDLE only, start has priority)
//   busy               : operation in progress
//   done               : one-cycle pulse after HI/LO are written by an op
//   div_by_zero        : last divide had a zero divisor
//   hi, lo             : architectural HI/LO registers
// Multiply is shift-add on magnitudes, divide is restoring on magnitudes;
// signs are applied in the single FIX cycle.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int ITER  = WIDTH;
    localparam int CNT_W = $clog2(ITER) + 1;

    state_t               state, next_state;
    mdu_op_e              op_r;
    logic [WIDTH-1:0]     a_r;          // multiplicand / unused for divide
    logic [WIDTH-1:0]     b_r;          // divisor / unused for multiply
    logic [WIDTH-1:0]     src1_raw;
    logic                 s1_neg, s2_neg, zero_div;
    logic [CNT_W-1:0]     cnt;
    logic [2*WIDTH-1:0]   acc;          // multiply: {partial, multiplier}; divide: {rem, quot}
    logic [WIDTH-1:0]     hi_r, lo_r;
    logic                 done_r, dbz_r;

    // Operand magnitudes at the start edge
    logic                 signed_in;
    logic [WIDTH-1:0]     a_mag, b_mag;

    assign signed_in = (op == MDU_MULT) || (op == MDU_DIV);

    negate_32bit #(.W(WIDTH)) u_abs1 (
        .din  (src1),
        .en   (signed_in & src1[WIDTH-1]),
        .dout (a_mag)
    );

    negate_32bit #(.W(WIDTH)) u_abs2 (
        .din  (src2),
        .en   (signed_in & src2[WIDTH-1]),
        .dout (b_mag)
    );

    // One iteration step
    logic                 is_div;
    logic [WIDTH:0]       add_sum;
    logic [WIDTH:0]       rem_sh;
    logic [WIDTH:0]       trial;
    logic [2*WIDTH-1:0]   mul_next, div_next;

    assign is_div = op_r[1];

    always_comb begin
        add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, a_r};
        // The carry-out of the add becomes the new MSB after the shift.
        mul_next = acc[0] ? {add_sum, acc[WIDTH-1:1]}
                          : {1'b0, acc[2*WIDTH-1:1]};
        // Shifted remainder needs one extra bit before the trial subtract.
        rem_sh   = acc[2*WIDTH-1:WIDTH-1];
        trial    = rem_sh - {1'b0, b_r};
        div_next = trial[WIDTH] ? {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                : {trial[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};
    end

    // Sign fix of the final accumulator
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quot_fix, rem_fix;

    negate_32bit #(.W(2*WIDTH)) u_prod_fix (
        .din  (acc),
        .en   ((op_r == MDU_MULT) & (s1_neg ^ s2_neg)),
        .dout (prod_fix)
    );

    negate_32bit #(.W(WIDTH)) u_quot_fix (
        .din  (acc[WIDTH-1:0]),
        .en   ((op_r == MDU_DIV) & (s1_neg ^ s2_neg)),
        .dout (quot_fix)
    );

    negate_32bit #(.W(WIDTH)) u_rem_fix (
        .din  (acc[2*WIDTH-1:WIDTH]),
        .en   ((op_r == MDU_DIV) & s1_neg),
        .dout (rem_fix)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and status
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (cnt == CNT_W'(ITER - 1)) begin
                    next_state = FIX;
                end
            end
            FIX: begin
                busy       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            op_r     <= MDU_MULT;
            a_r      <= '0;
            b_r      <= '0;
            src1_raw <= '0;
            s1_neg   <= 1'b0;
            s2_neg   <= 1'b0;
            zero_div <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
            hi_r     <= '0;
            lo_r     <= '0;
            done_r   <= 1'b0;
            dbz_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_r     <= mdu_op_e'(op);
                        a_r      <= a_mag;
                        b_r      <= b_mag;
                        src1_raw <= src1;
                        s1_neg   <= signed_in & src1[WIDTH-1];
                        s2_neg   <= signed_in & src2[WIDTH-1];
                        zero_div <= (src2 == '0);
                        cnt      <= '0;
                        acc      <= {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
                    end else begin
                        if (hi_we) hi_r <= wdata;
                        if (lo_we) lo_r <= wdata;
                    end
                end
                CALC: begin
                    acc <= is_div ? div_next : mul_next;
                    cnt <= cnt + CNT_W'(1);
                end
                FIX: begin
                    done_r <= 1'b1;
                    if (is_div && zero_div) begin
                        hi_r  <= src1_raw;
                        lo_r  <= DIV0_LO;
                        dbz_r <= 1'b1;
                    end else if (is_div) begin
                        hi_r  <= rem_fix;
                        lo_r  <= quot_fix;
                        dbz_r <= 1'b0;
                    end else begin
                        hi_r  <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_r  <= prod_fix[WIDTH-1:0];
                        dbz_r <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign done        = done_r;
    assign div_by_zero = dbz_r;
    assign hi          = hi_r;
    assign lo          = lo_r;

endmodule
